// File: rtl/computer_player.sv
// rtl/computer_player.sv - tic-tac-toe computer opponent: win scan, block scan, fixed fallback, retry on illegal_move
// Define CP_BLOCK_EN to include the SCAN_BLOCK pass between SCAN_WIN and FALLBACK.
module computer_player #(
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        go_i,
  input  logic        game_over_i,
  input  logic [17:0] board_data_i,
  input  logic        illegal_move_i,
  output logic        computer_move_o,
  output logic [3:0]  computer_adderss_o,
  output logic [1:0]  move_kind_o,
  output logic        busy_o,
  output logic        no_move_o,
  output logic        retry_fail_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SCAN_WIN = 3'd1;
  localparam logic [2:0] FALLBACK = 3'd3;
  localparam logic [2:0] ISSUE    = 3'd4;
  localparam logic [2:0] CHECK    = 3'd5;
`ifdef CP_BLOCK_EN
  localparam logic [2:0] SCAN_BLOCK = 3'd2;
`endif
  localparam logic [2:0] MAX_R = MAX_RETRY[2:0];

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [17:0] snap_q, snap_d;
  logic [2:0]  retry_q, retry_d;
  logic        move_q, move_d;
  logic [3:0]  addr_q, addr_d;
  logic [1:0]  kind_q, kind_d;
  logic        busy_q, busy_d;
  logic        no_move_q, no_move_d;
  logic        retry_fail_q, retry_fail_d;

  // Three cell numbers of a line packed {c2, c1, c0}
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    line_cells = {4'd2, 4'd1, 4'd0};
      3'd1:    line_cells = {4'd5, 4'd4, 4'd3};
      3'd2:    line_cells = {4'd8, 4'd7, 4'd6};
      3'd3:    line_cells = {4'd6, 4'd3, 4'd0};
      3'd4:    line_cells = {4'd7, 4'd4, 4'd1};
      3'd5:    line_cells = {4'd8, 4'd5, 4'd2};
      3'd6:    line_cells = {4'd8, 4'd4, 4'd0};
      default: line_cells = {4'd6, 4'd4, 4'd2};
    endcase
  endfunction

  function automatic logic [3:0] fb_cell(input logic [3:0] i);
    case (i)
      4'd0:    fb_cell = 4'd4;
      4'd1:    fb_cell = 4'd0;
      4'd2:    fb_cell = 4'd2;
      4'd3:    fb_cell = 4'd6;
      4'd4:    fb_cell = 4'd8;
      4'd5:    fb_cell = 4'd1;
      4'd6:    fb_cell = 4'd3;
      4'd7:    fb_cell = 4'd5;
      default: fb_cell = 4'd7;
    endcase
  endfunction

  function automatic logic [1:0] cell_val(input logic [17:0] b, input logic [3:0] c);
    logic [17:0] sh;
    sh = b >> {c, 1'b0};
    cell_val = sh[1:0];
  endfunction

  logic [11:0] line_w;
  logic [3:0]  c0, c1, c2, empty_cell, fb_c;
  logic [1:0]  v0, v1, v2, mv, n_match, n_empty;
  logic        hit, fb_empty;

  always_comb begin
    line_w = line_cells(idx_q[2:0]);
    c0 = line_w[3:0];
    c1 = line_w[7:4];
    c2 = line_w[11:8];
    v0 = cell_val(snap_q, c0);
    v1 = cell_val(snap_q, c1);
    v2 = cell_val(snap_q, c2);
    mv = 2'b10;
`ifdef CP_BLOCK_EN
    if (state_q == SCAN_BLOCK) mv = 2'b01;
`endif
    n_match = {1'b0, v0 == mv} + {1'b0, v1 == mv} + {1'b0, v2 == mv};
    n_empty = {1'b0, v0 == 2'b00} + {1'b0, v1 == 2'b00} + {1'b0, v2 == 2'b00};
    hit = (n_match == 2'd2) && (n_empty == 2'd1);
    empty_cell = (v0 == 2'b00) ? c0 : ((v1 == 2'b00) ? c1 : c2);
    fb_c = fb_cell(idx_q);
    fb_empty = (cell_val(snap_q, fb_c) == 2'b00);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    retry_d      = retry_q;
    move_d       = 1'b0;
    addr_d       = addr_q;
    kind_d       = kind_q;
    no_move_d    = 1'b0;
    retry_fail_d = 1'b0;
    case (state_q)
      IDLE: begin
        retry_d = 3'd0;
        // busy_q can still be high here during the pulse cycle that ends a request
        if (go_i && !game_over_i && !busy_q) begin
          snap_d  = board_data_i;
          idx_d   = 4'd0;
          state_d = SCAN_WIN;
        end
      end
      SCAN_WIN: begin
        if (hit) begin
          addr_d  = empty_cell;
          kind_d  = 2'b01;
          move_d  = 1'b1;
          state_d = ISSUE;
        end else if (idx_q == 4'd7) begin
          idx_d = 4'd0;
`ifdef CP_BLOCK_EN
          state_d = SCAN_BLOCK;
`else
          state_d = FALLBACK;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`ifdef CP_BLOCK_EN
      SCAN_BLOCK: begin
        if (hit) begin
          addr_d  = empty_cell;
          kind_d  = 2'b10;
          move_d  = 1'b1;
          state_d = ISSUE;
        end else if (idx_q == 4'd7) begin
          idx_d   = 4'd0;
          state_d = FALLBACK;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`endif
      FALLBACK: begin
        if (fb_empty) begin
          addr_d  = fb_c;
          kind_d  = 2'b11;
          move_d  = 1'b1;
          state_d = ISSUE;
        end else if (idx_q == 4'd8) begin
          no_move_d = 1'b1;
          state_d   = IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        if (illegal_move_i && (retry_q < MAX_R)) begin
          retry_d = retry_q + 3'd1;
          snap_d  = board_data_i;
          idx_d   = 4'd0;
          state_d = SCAN_WIN;
        end else begin
          retry_fail_d = illegal_move_i;
          retry_d      = 3'd0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort: no new strobe, no pulses; an already-issued strobe has completed on its own
    if ((state_q != IDLE) && game_over_i) begin
      state_d      = IDLE;
      retry_d      = 3'd0;
      move_d       = 1'b0;
      addr_d       = addr_q;
      kind_d       = kind_q;
      no_move_d    = 1'b0;
      retry_fail_d = 1'b0;
    end
    busy_d = (state_d != IDLE) || no_move_d || retry_fail_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      snap_q       <= 18'd0;
      retry_q      <= 3'd0;
      move_q       <= 1'b0;
      addr_q       <= 4'd0;
      kind_q       <= 2'b00;
      busy_q       <= 1'b0;
      no_move_q    <= 1'b0;
      retry_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      retry_q      <= retry_d;
      move_q       <= move_d;
      addr_q       <= addr_d;
      kind_q       <= kind_d;
      busy_q       <= busy_d;
      no_move_q    <= no_move_d;
      retry_fail_q <= retry_fail_d;
    end
  end

  assign computer_move_o    = move_q;
  assign computer_adderss_o = addr_q;
  assign move_kind_o        = kind_q;
  assign busy_o             = busy_q;
  assign no_move_o          = no_move_q;
  assign retry_fail_o       = retry_fail_q;

endmodule

// File: tb/tb_computer_player.sv
// tb/tb_computer_player.sv - self-checking bench for computer_player against a rule-level move model
module tb_computer_player;

  localparam int MAX_RETRY = 2;
`ifdef CP_BLOCK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        go, game_over, illegal;
  logic [17:0] board;
  logic        mv_o, busy_o, nm_o, rf_o;
  logic [3:0]  addr_o;
  logic [1:0]  kind_o;

  int n_cmp = 0, n_fail = 0;
  int e_mv, e_addr, e_kind, e_busy, e_nm, e_rf;
  int last_addr = 0, last_kind = 0;
  bit chk_en = 1'b0;

  computer_player #(.MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rstn(rstn), .go_i(go), .game_over_i(game_over),
    .board_data_i(board), .illegal_move_i(illegal),
    .computer_move_o(mv_o), .computer_adderss_o(addr_o), .move_kind_o(kind_o),
    .busy_o(busy_o), .no_move_o(nm_o), .retry_fail_o(rf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("computer_move", int'(mv_o), e_mv);
      check("computer_adderss", int'(addr_o), e_addr);
      check("move_kind", int'(kind_o), e_kind);
      check("busy", int'(busy_o), e_busy);
      check("no_move", int'(nm_o), e_nm);
      check("retry_fail", int'(rf_o), e_rf);
    end
  end

  function automatic int cellv(input logic [17:0] b, input int i);
    return int'((b >> (2 * i)) & 18'h3);
  endfunction

  function automatic logic [17:0] put(input logic [17:0] b, input int i, input logic [1:0] v);
    logic [17:0] r;
    r = b;
    r[2*i +: 2] = v;
    return r;
  endfunction

  // lat: cycles from the request/rescan cycle to the strobe (or to the no_move pulse)
  function automatic void model(input logic [17:0] b, output bit found, output int addr,
                                output int kind, output int lat);
    int fb[9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
    int c[3];
    int nscan, m, e, ecell, want;
    found = 0; addr = 0; kind = 0; lat = 0; nscan = 0;
    for (int p = 0; p < (BLK ? 2 : 1); p++) begin
      want = (p == 0) ? 2 : 1;
      for (int l = 0; l < 8; l++) begin
        if (l < 3) begin c[0] = 3*l; c[1] = 3*l + 1; c[2] = 3*l + 2; end
        else if (l < 6) begin c[0] = l - 3; c[1] = l; c[2] = l + 3; end
        else if (l == 6) begin c[0] = 0; c[1] = 4; c[2] = 8; end
        else begin c[0] = 2; c[1] = 4; c[2] = 6; end
        m = 0; e = 0; ecell = 0;
        for (int k = 0; k < 3; k++) begin
          if (cellv(b, c[k]) == want) m++;
          else if (cellv(b, c[k]) == 0) begin e++; ecell = c[k]; end
        end
        if (m == 2 && e == 1) begin
          found = 1; addr = ecell; kind = p + 1; lat = nscan + l + 2;
          return;
        end
      end
      nscan += 8;
    end
    for (int p = 0; p < 9; p++) begin
      if (cellv(b, fb[p]) == 0) begin
        found = 1; addr = fb[p]; kind = 3; lat = nscan + p + 2;
        return;
      end
    end
    lat = nscan + 10;
  endfunction

  task automatic request(input logic [17:0] b, input int n_ill, input int abort_at, input bit hold_go);
    int a_mv[64], a_nm[64], a_rf[64], a_bz[64], a_ill[64], a_addr[64], a_kind[64];
    bit found, done;
    int addr, kind, lat, s, att, busy_end, last;
    for (int t = 0; t < 64; t++) begin
      a_mv[t] = 0; a_nm[t] = 0; a_rf[t] = 0; a_bz[t] = 0; a_ill[t] = 0; a_addr[t] = 0; a_kind[t] = 0;
    end
    s = 0; att = 0; busy_end = 0; done = 0;
    while (!done) begin
      model(b, found, addr, kind, lat);
      if (!found) begin
        a_nm[s+lat] = 1; busy_end = s + lat + 1; done = 1;
      end else begin
        a_mv[s+lat] = 1; a_addr[s+lat] = addr; a_kind[s+lat] = kind;
        if (att < n_ill) begin
          a_ill[s+lat+1] = 1;
          if (att < MAX_RETRY) begin att++; s = s + lat + 1; end
          else begin a_rf[s+lat+2] = 1; busy_end = s + lat + 3; done = 1; end
        end else begin
          busy_end = s + lat + 2; done = 1;
        end
      end
    end
    for (int t = 1; t < busy_end; t++) a_bz[t] = 1;
    last = busy_end;
    if (abort_at > 0) begin
      for (int t = abort_at + 1; t < 64; t++) begin
        a_mv[t] = 0; a_nm[t] = 0; a_rf[t] = 0; a_bz[t] = 0; a_ill[t] = 0;
      end
      if (abort_at + 1 < last) last = abort_at + 1;
    end
    for (int t = 0; t <= last + 2; t++) begin
      @(posedge clk); #1;
      go = (t == 0) || (hold_go && t < last);
      game_over = (t == abort_at);
      board = b;
      illegal = (a_ill[t] != 0);
      if (a_mv[t] != 0) begin last_addr = a_addr[t]; last_kind = a_kind[t]; end
      e_mv = a_mv[t]; e_nm = a_nm[t]; e_rf = a_rf[t]; e_busy = a_bz[t];
      e_addr = last_addr; e_kind = last_kind;
    end
  endtask

  logic [17:0] b_win, b_blk, b_l7, b_prio, b_ctr, b_full;
  bit   f;
  int   a, k, l;

  initial begin
    rstn = 1'b0; go = 1'b0; game_over = 1'b0; illegal = 1'b0; board = 18'd0;
    e_mv = 0; e_addr = 0; e_kind = 0; e_busy = 0; e_nm = 0; e_rf = 0;
    chk_en = 1'b1;
    b_win  = put(put(put(put(18'd0, 0, 2'b10), 1, 2'b10), 3, 2'b01), 4, 2'b01);
    b_blk  = put(put(put(18'd0, 0, 2'b01), 1, 2'b01), 4, 2'b10);
    b_l7   = put(put(18'd0, 2, 2'b10), 6, 2'b10);
    b_prio = put(put(put(put(18'd0, 6, 2'b10), 7, 2'b10), 0, 2'b01), 1, 2'b01);
    b_ctr  = put(18'd0, 4, 2'b01);
    b_full = 18'd0;
    for (int i = 0; i < 9; i++) b_full = put(b_full, i, (i inside {1, 4, 5, 6}) ? 2'b01 : 2'b10);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    model(18'd0, f, a, k, l);
    check("pin_empty_lat", l, BLK ? 18 : 10);
    check("pin_empty_addr", a, 4);
    check("pin_empty_kind", k, 3);
    model(b_win, f, a, k, l);
    check("pin_win_lat", l, 2);
    check("pin_win_addr", a, 2);
    check("pin_win_kind", k, 1);
    model(b_blk, f, a, k, l);
    check("pin_blk_lat", l, BLK ? 10 : 12);
    check("pin_blk_addr", a, 2);
    check("pin_blk_kind", k, BLK ? 2 : 3);
    model(b_full, f, a, k, l);
    check("pin_full_found", int'(f), 0);
    check("pin_full_lat", l, BLK ? 26 : 18);

    request(18'd0, 0, -1, 1'b0);
    request(b_win, 0, -1, 1'b0);
    request(b_blk, 0, -1, 1'b0);
    request(b_l7, 0, -1, 1'b0);
    request(b_prio, 0, -1, 1'b0);
    request(b_ctr, 0, -1, 1'b0);
    request(b_full, 0, -1, 1'b1);

    @(posedge clk); #1 go = 1'b1; game_over = 1'b1;
    repeat (4) @(posedge clk);
    #1 go = 1'b0; game_over = 1'b0;

    request(b_win, 3, -1, 1'b0);
    request(b_win, 1, -1, 1'b0);
    request(18'd0, 0, 5, 1'b0);

    // Async reset two cycles into a scan: outputs must clear before the next edge
    @(posedge clk); #1 go = 1'b1; board = 18'd0;
    @(posedge clk); #1 go = 1'b0; e_busy = 1;
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    check("rst_busy", int'(busy_o), 0);
    check("rst_move", int'(mv_o), 0);
    check("rst_addr", int'(addr_o), 0);
    check("rst_kind", int'(kind_o), 0);
    check("rst_no_move", int'(nm_o), 0);
    check("rst_retry_fail", int'(rf_o), 0);
    last_addr = 0; last_kind = 0;
    e_mv = 0; e_addr = 0; e_kind = 0; e_busy = 0; e_nm = 0; e_rf = 0;
    @(posedge clk); #1 rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
